piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parallel-in, serial-out transmitter. It is the sending end of the 4-bit serial shift-register link.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Emits the word one bit per enabled clock on shift_out, MSB first, so a serial-in receiver shifting into bit 0 ends the frame with the word in its original bit order.
- Supports back-to-back frames with zero gap, and stalling via shift_en.

Parameters:
WIDTH, 4, word width in bits; legal range 2..32.
MSB_FIRST, 1, 1 = transmit data[WIDTH-1] first; 0 = transmit data[0] first.

Ports:
CLK  input  1  clock; all state changes on posedge CLK.
Reset  input  1  reset, synchronous, active-high.
load_data  input  WIDTH  parallel word to transmit.
load_valid  input  1  load_data is valid.
load_ready  output  1  serializer can accept a word this cycle.
shift_en  input  1  bit-advance enable; a bit is consumed at posedge when shift_valid && shift_en.
shift_out  output  1  serial data bit.
shift_valid  output  1  shift_out carries a frame bit.
frame_start  output  1  high while the first bit of a frame is on shift_out.
busy  output  1  high in any non-IDLE state.

Behaviour:
- Reset (CLK=1 edge with Reset=1) wins over all other inputs. Reset takes effect mid-frame and discards the in-flight word.
- Values after reset: state=IDLE, shift register=0, bit_cnt=0, shift_out=0, shift_valid=0, frame_start=0, busy=0, load_ready=1.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs except into load_ready (see the load_ready rule).
- State IDLE:
  - shift_out=0, shift_valid=0, load_ready=1.
  - On load_valid=1: capture load_data into sreg, bit_cnt<=0, go to SHIFT.
  - First bit appears on shift_out the cycle after acceptance; latency from acceptance to first bit is 1 cycle.
- State SHIFT:
  - shift_valid=1; shift_out = sreg[WIDTH-1] (MSB_FIRST=1) or sreg[0] (MSB_FIRST=0).
  - frame_start = (bit_cnt==0).
  - shift_en=0: hold sreg, bit_cnt and shift_out unchanged, for any number of cycles.
  - shift_en=1 and bit_cnt<WIDTH-1: shift sreg one place toward the output end (fill 0), bit_cnt<=bit_cnt+1.
  - shift_en=1 and bit_cnt==WIDTH-1 (last bit):
    - with PISO_PARITY_EN, go to PARITY;
    - else if load_valid=1, capture new word, bit_cnt<=0, stay in SHIFT (zero-gap back-to-back);
    - else go to IDLE.
- load_ready = (state==IDLE) || (state==SHIFT && bit_cnt==WIDTH-1 && shift_en && no parity) || (state==PARITY && shift_en).
- load_data is ignored while load_ready=0. A word is accepted only on load_valid && load_ready at posedge.
- bit_cnt width is clog2(WIDTH). It never exceeds WIDTH-1 and never wraps.
- Frame length is exactly WIDTH consumed bits (WIDTH+1 with parity).

Optional Feature:
Macro PISO_PARITY_EN.
- Defined:
  - State PARITY is compiled in. After the last data bit is consumed, shift_out = even parity (XOR of the captured word), shift_valid=1, frame_start=0.
  - PARITY holds while shift_en=0.
  - On shift_en=1: accept a new word if load_valid (go to SHIFT, bit_cnt<=0), else go to IDLE.
  - The parity value is registered at word capture.
- Undefined: no PARITY state, no parity register; the frame is data bits only.

Test Plan:
1. Reset, then load 4'b1011 with shift_en=1 constant -> shift_out 1,0,1,1 on the 4 cycles after acceptance; shift_valid high exactly 4 cycles; frame_start high only on the first; load_ready low on the first 3 bit cycles and high on the 4th.
2. Loopback into the 4-bit serial-in receiver clocked with shift_en=1, load 4'b0110 -> after 4 bit cycles the receiver holds Bit_3..Bit_0 = 0,1,1,0.
3. Back-to-back: load 4'hA then 4'h5 with load_valid held -> 8 contiguous valid bits 1,0,1,0,0,1,0,1; no idle cycle between frames; frame_start pulses on bits 1 and 5.
4. Stall: load 4'b1100, drop shift_en for 3 cycles after the 2nd bit -> shift_out stays 1 and shift_valid stays 1 for the 3 stall cycles; the remaining bits are 0,0; total valid cycles 7.
5. Reset mid-frame after 2 bits of 4'b1111 -> next cycle shift_out=0, shift_valid=0, busy=0, load_ready=1; a following load of 4'b0001 emits 0,0,0,1.
6. With PISO_PARITY_EN, load 4'b1011 -> emits 1,0,1,1 then parity bit 1 (5 valid cycles); load 4'b1001 -> parity bit 0.

Source files
------------

// File: rtl/piso_serializer_if.sv
// Load/serial handshake bundle for piso_serializer.
// The master side is the host feeding words and pacing bits.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             shift_out;
  logic             shift_valid;
  logic             frame_start;
  logic             busy;

  modport master (
    output load_data,
    output load_valid,
    output shift_en,
    input  load_ready,
    input  shift_out,
    input  shift_valid,
    input  frame_start,
    input  busy
  );

  modport slave (
    input  load_data,
    input  load_valid,
    input  shift_en,
    output load_ready,
    output shift_out,
    output shift_valid,
    output frame_start,
    output busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with zero-gap back-to-back frames.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input logic              CLK,
  input logic              Reset,
  piso_serializer_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef PISO_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             so_q, so_d;
  logic             sv_q, sv_d;
  logic             fs_q, fs_d;
  logic             bz_q, bz_d;
  logic             ready;
  logic             last;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  assign last = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
      end
      SHIFT: begin
        if (bus.shift_en) begin
          if (!last) begin
            cnt_d = cnt_q + 1'b1;
            if (MSB_FIRST != 0)
              sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            else
              sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
          end else begin
`ifdef PISO_PARITY_EN
            state_d = PARITY;
`else
            ready   = 1'b1;
            state_d = IDLE;
`endif
          end
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        if (bus.shift_en) begin
          ready   = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
    // Acceptance overrides any IDLE transition chosen above.
    if (ready && bus.load_valid) begin
      state_d = SHIFT;
      sreg_d  = bus.load_data;
      cnt_d   = '0;
`ifdef PISO_PARITY_EN
      par_d   = ^bus.load_data;
`endif
    end
  end

  always_comb begin
    so_d = 1'b0;
    sv_d = 1'b0;
    fs_d = 1'b0;
    bz_d = (state_d != IDLE);
    unique case (state_d)
      SHIFT: begin
        so_d = (MSB_FIRST != 0) ? sreg_d[WIDTH-1]
                                : sreg_d[0];
        sv_d = 1'b1;
        fs_d = (cnt_d == '0);
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        so_d = par_d;
        sv_d = 1'b1;
      end
`endif
      default: begin
        so_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      so_q    <= 1'b0;
      sv_q    <= 1'b0;
      fs_q    <= 1'b0;
      bz_q    <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      so_q    <= so_d;
      sv_q    <= sv_d;
      fs_q    <= fs_d;
      bz_q    <= bz_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.load_ready  = ready;
  assign bus.shift_out   = so_q;
  assign bus.shift_valid = sv_q;
  assign bus.frame_start = fs_q;
  assign bus.busy        = bz_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed vector bench for piso_serializer (WIDTH=4, MSB first).
// Expected outputs packed as {shift_out, valid, frame_start, busy, ready}.
module tb_piso_serializer;

  logic CLK = 1'b0;
  logic Reset;

  piso_serializer_if #(.WIDTH(4)) bus ();

  piso_serializer #(
    .WIDTH(4),
    .MSB_FIRST(1)
  ) dut (
    .CLK(CLK),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       lv;
    logic [3:0] d;
    logic       en;
    logic [4:0] exp;
  } vec_t;

  vec_t tv[$];
  int   tests = 0;
  int   fails = 0;
  logic [3:0] rx;

  // Serial-in receiver: shifts each consumed bit into bit 0.
  always @(posedge CLK) begin
    if (Reset)
      rx <= 4'b0;
    else if (bus.shift_valid && bus.shift_en)
      rx <= {rx[2:0], bus.shift_out};
  end

  function automatic vec_t mk(logic r, logic lv,
                              logic [3:0] d, logic en,
                              logic [4:0] e);
    vec_t v;
    v.rst = r; v.lv = lv; v.d = d;
    v.en = en; v.exp = e;
    return v;
  endfunction

  task automatic drive(logic r, logic lv,
                       logic [3:0] d, logic en);
    Reset          = r;
    bus.load_valid = lv;
    bus.load_data  = d;
    bus.shift_en   = en;
  endtask

  initial begin
    logic [4:0] act;
    logic [3:0] rx_exp;
`ifdef PISO_PARITY_EN
    tv.push_back(mk(0, 1, 4'hB, 1, 5'b00001));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b11110));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b01010));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b11010));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b11010));
    tv.push_back(mk(0, 1, 4'h9, 1, 5'b11011));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b11110));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b01010));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b01010));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b11010));
    tv.push_back(mk(0, 0, 4'h0, 0, 5'b01010));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b01011));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b00001));
    rx_exp = 4'b1100;
`else
    tv.push_back(mk(0, 1, 4'hB, 1, 5'b00001));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b11110));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b01010));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b11010));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b11011));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b00001));
    tv.push_back(mk(0, 1, 4'hA, 1, 5'b00001));
    tv.push_back(mk(0, 1, 4'h5, 1, 5'b11110));
    tv.push_back(mk(0, 1, 4'h5, 1, 5'b01010));
    tv.push_back(mk(0, 1, 4'h5, 1, 5'b11010));
    tv.push_back(mk(0, 1, 4'h5, 1, 5'b01011));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b01110));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b11010));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b01010));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b11011));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b00001));
    tv.push_back(mk(0, 1, 4'hC, 1, 5'b00001));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b11110));
    tv.push_back(mk(0, 0, 4'h0, 0, 5'b11010));
    tv.push_back(mk(0, 0, 4'h0, 0, 5'b11010));
    tv.push_back(mk(0, 0, 4'h0, 0, 5'b11010));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b11010));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b01010));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b01011));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b00001));
    tv.push_back(mk(0, 1, 4'hF, 1, 5'b00001));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b11110));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b11010));
    tv.push_back(mk(1, 0, 4'h0, 1, 5'b11010));
    tv.push_back(mk(0, 1, 4'h1, 1, 5'b00001));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b01110));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b01010));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b01010));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b11011));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b00001));
    tv.push_back(mk(0, 1, 4'h3, 1, 5'b00001));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b01110));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b01010));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b11010));
    tv.push_back(mk(0, 1, 4'hF, 0, 5'b11010));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b11011));
    tv.push_back(mk(0, 0, 4'h0, 1, 5'b00001));
    rx_exp = 4'b0110;
`endif

    drive(1, 0, 4'h0, 0);
    repeat (2) @(negedge CLK);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge CLK);
      drive(tv[i].rst, tv[i].lv, tv[i].d, tv[i].en);
      #1;
      act = {bus.shift_out, bus.shift_valid,
             bus.frame_start, bus.busy,
             bus.load_ready};
      tests++;
      if (act !== tv[i].exp) begin
        fails++;
        $display("FAIL vec%0d: got %b want %b",
                 i, act, tv[i].exp);
      end
    end

    @(negedge CLK);
    drive(1, 0, 4'h0, 1);
    @(negedge CLK);
    drive(0, 1, 4'h6, 1);
    @(negedge CLK);
    drive(0, 0, 4'h0, 1);
    repeat (7) @(negedge CLK);
    #1;
    tests++;
    if (rx !== rx_exp) begin
      fails++;
      $display("FAIL loopback: got %b want %b",
               rx, rx_exp);
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
